// File: rtl/ct_fadd_wb_buf.sv
// Writeback buffer for the VFALU fadd pipe: FIFO plus credit-based issue-ready.
// Define FADD_WB_BYPASS_EN to let an EX3 result reach an empty buffer's wb port in the same cycle.

module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_bf_latch;
  logic clk_en_af_latch;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Enable is captured while the clock is low so clk_out never glitches.
  always_latch begin
    if (!clk_in) clk_en_af_latch <= clk_en_bf_latch;
  end

  assign clk_out = clk_in & (clk_en_af_latch | pad_yy_icg_scan_en);
endmodule

module ct_fadd_wb_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              cp0_yy_clk_en,
  input  logic              cp0_vfpu_icg_en,
  input  logic              pad_yy_icg_scan_en,
  input  logic              ex1_pipedown,
  input  logic              ex2_pipedown,
  input  logic              ex3_pipedown,
  input  logic [DATA_W-1:0] ex3_result,
  input  logic [4:0]        ex3_fflags,
  input  logic [6:0]        ex3_preg,
  input  logic              rtu_yy_xx_flush,
  input  logic              wb_grant,
  output logic              wb_req,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_fflags,
  output logic [6:0]        wb_preg,
  output logic              fadd_issue_ready,
  output logic              wb_overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  logic [PW:0]       wptr;
  logic [PW:0]       rptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] ent_data   [DEPTH];
  logic [4:0]        ent_fflags [DEPTH];
  logic [6:0]        ent_preg   [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic byp_vld;
  logic byp_take;
  logic pop;
  logic push_req;
  logic overflow;
  logic push;
  logic entry_clk;
  logic ctrl_clk;
  logic ctrl_clk_en;
  logic [CW-1:0] credit_sum;

  // Wrap bit makes the pointer difference the occupancy directly.
  assign count      = wptr - rptr;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(DEPTH));

`ifdef FADD_WB_BYPASS_EN
  assign byp_vld  = fifo_empty & ex3_pipedown & ~rtu_yy_xx_flush;
  assign byp_take = byp_vld & wb_grant;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign wb_req   = ~fifo_empty | byp_vld;
  assign pop      = ~fifo_empty & wb_grant & ~rtu_yy_xx_flush;
  assign push_req = ex3_pipedown & ~rtu_yy_xx_flush & ~byp_take;
  assign overflow = push_req & fifo_full & ~pop;
  assign push     = push_req & ~overflow;

  assign wb_data   = byp_vld ? ex3_result : ent_data[rptr[PW-1:0]];
  assign wb_fflags = byp_vld ? ex3_fflags : ent_fflags[rptr[PW-1:0]];
  assign wb_preg   = byp_vld ? ex3_preg   : ent_preg[rptr[PW-1:0]];

  // Ops already in EX1..EX3 cannot stall, so they are reserved against free space.
  assign credit_sum = CW'(count) + CW'(ex1_pipedown) + CW'(ex2_pipedown) + CW'(ex3_pipedown);
  assign fadd_issue_ready = (credit_sum < CW'(DEPTH));

  assign ctrl_clk_en = ex3_pipedown | wb_req | rtu_yy_xx_flush;

  gated_clk_cell x_entry_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_vfpu_icg_en),
    .local_en           (push),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (entry_clk)
  );

  gated_clk_cell x_ctrl_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_vfpu_icg_en),
    .local_en           (ctrl_clk_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (ctrl_clk)
  );

  always_ff @(posedge entry_clk) begin
    if (push) begin
      ent_data[wptr[PW-1:0]]   <= ex3_result;
      ent_fflags[wptr[PW-1:0]] <= ex3_fflags;
      ent_preg[wptr[PW-1:0]]   <= ex3_preg;
    end
  end

  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wptr <= '0;
      rptr <= '0;
    end else if (rtu_yy_xx_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // Overflow only happens on an EX3 push, which always enables ctrl_clk.
  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) wb_overflow_err <= 1'b0;
    else if (overflow) wb_overflow_err <= 1'b1;
  end
endmodule

// File: tb/tb_ct_fadd_wb_buf.sv
// Bench for ct_fadd_wb_buf: directed and random steps against a queue-based reference model.
// Honours FADD_WB_BYPASS_EN the same way the design does.

module tb_ct_fadd_wb_buf;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
`ifdef FADD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              forever_cpuclk;
  logic              cpurst_b;
  logic              cp0_yy_clk_en;
  logic              cp0_vfpu_icg_en;
  logic              pad_yy_icg_scan_en;
  logic              ex1_pipedown;
  logic              ex2_pipedown;
  logic              ex3_pipedown;
  logic [DATA_W-1:0] ex3_result;
  logic [4:0]        ex3_fflags;
  logic [6:0]        ex3_preg;
  logic              rtu_yy_xx_flush;
  logic              wb_grant;
  logic              wb_req;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_fflags;
  logic [6:0]        wb_preg;
  logic              fadd_issue_ready;
  logic              wb_overflow_err;

  ct_fadd_wb_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst_b           (cpurst_b),
    .cp0_yy_clk_en      (cp0_yy_clk_en),
    .cp0_vfpu_icg_en    (cp0_vfpu_icg_en),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .ex1_pipedown       (ex1_pipedown),
    .ex2_pipedown       (ex2_pipedown),
    .ex3_pipedown       (ex3_pipedown),
    .ex3_result         (ex3_result),
    .ex3_fflags         (ex3_fflags),
    .ex3_preg           (ex3_preg),
    .rtu_yy_xx_flush    (rtu_yy_xx_flush),
    .wb_grant           (wb_grant),
    .wb_req             (wb_req),
    .wb_data            (wb_data),
    .wb_fflags          (wb_fflags),
    .wb_preg            (wb_preg),
    .fadd_issue_ready   (fadd_issue_ready),
    .wb_overflow_err    (wb_overflow_err)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Reference: entries are {data, fflags, preg}, oldest at index 0.
  logic [DATA_W+11:0] mq[$];
  logic               m_err;
  int                 vectors;
  int                 miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic               e_req;
    logic [DATA_W+11:0] e_head;
    int                 sum;
    e_req = (mq.size() != 0) || (BYP && ex3_pipedown && !rtu_yy_xx_flush);
    e_head = (mq.size() != 0) ? mq[0] : {ex3_result, ex3_fflags, ex3_preg};
    sum = mq.size() + int'(ex1_pipedown) + int'(ex2_pipedown) + int'(ex3_pipedown);
    chk("wb_req", 64'(wb_req), 64'(e_req));
    if (e_req) begin
      chk("wb_data", wb_data, e_head[DATA_W+11:12]);
      chk("wb_fflags", 64'(wb_fflags), 64'(e_head[11:7]));
      chk("wb_preg", 64'(wb_preg), 64'(e_head[6:0]));
    end
    chk("issue_ready", 64'(fadd_issue_ready), 64'(sum < DEPTH));
    chk("overflow_err", 64'(wb_overflow_err), 64'(m_err));
  endtask

  task automatic model_update();
    int sz;
    bit pop;
    bit byp;
    sz = mq.size();
    if (rtu_yy_xx_flush) begin
      mq.delete();
    end else begin
      byp = BYP && sz == 0 && ex3_pipedown && wb_grant;
      pop = sz != 0 && wb_grant;
      if (ex3_pipedown && !byp && sz == DEPTH && !pop) begin
        m_err = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (ex3_pipedown && !byp) mq.push_back({ex3_result, ex3_fflags, ex3_preg});
      end
    end
  endtask

  task automatic step(input logic e1, input logic e2, input logic e3, input logic gr,
                      input logic fl, input logic [DATA_W-1:0] res, input logic [4:0] ff,
                      input logic [6:0] pr);
    @(negedge forever_cpuclk);
    ex1_pipedown    = e1;
    ex2_pipedown    = e2;
    ex3_pipedown    = e3;
    wb_grant        = gr;
    rtu_yy_xx_flush = fl;
    ex3_result      = res;
    ex3_fflags      = ff;
    ex3_preg        = pr;
    #1;
    check_outputs();
    model_update();
  endtask

  task automatic rstep(input logic e1, input logic e2, input logic e3, input logic gr,
                       input logic fl);
    step(e1, e2, e3, gr, fl, {$urandom, $urandom}, 5'($urandom), 7'($urandom));
  endtask

  task automatic zero_inputs();
    ex1_pipedown = 0; ex2_pipedown = 0; ex3_pipedown = 0;
    wb_grant = 0; rtu_yy_xx_flush = 0;
    ex3_result = '0; ex3_fflags = '0; ex3_preg = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_err = 1'b0;
    cp0_yy_clk_en = 1'b1;
    cp0_vfpu_icg_en = 1'b0;
    pad_yy_icg_scan_en = 1'b0;
    zero_inputs();
    cpurst_b = 1'b0;
    #23;
    check_outputs();
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // Single op with grant held high.
    step(0, 0, 1, 1, 0, 64'h3FF0_0000_0000_0000, 5'h0, 7'd5);
    rstep(0, 0, 0, 1, 0);
    rstep(0, 0, 0, 1, 0);

    // Backpressure: fill without grant, hold, then drain in order.
    for (int i = 0; i < 4; i++) rstep(0, 0, 1, 0, 0);
    rstep(0, 0, 0, 0, 0);
    rstep(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rstep(0, 0, 0, 1, 0);
    rstep(0, 0, 0, 0, 0);

    // Credit accounting with two entries held.
    rstep(0, 0, 1, 0, 0);
    rstep(0, 0, 1, 0, 0);
    rstep(1, 1, 0, 0, 0);
    rstep(1, 0, 0, 0, 0);

    // Full with push plus pop, then a dropped push.
    rstep(0, 0, 1, 0, 0);
    rstep(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) rstep(0, 0, 1, 1, 0);
    rstep(0, 0, 0, 0, 0);
    rstep(0, 0, 1, 0, 0);
    rstep(0, 0, 0, 0, 0);
    rstep(0, 0, 0, 0, 0);

    // Flush at three entries with an EX3 push in the same cycle.
    rstep(0, 0, 0, 1, 0);
    rstep(0, 0, 1, 1, 1);
    rstep(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) rstep(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) rstep(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) rstep(0, 0, 0, 1, 0);

    // Asynchronous reset with two entries held, mid high phase.
    rstep(0, 0, 1, 0, 0);
    rstep(0, 0, 1, 0, 0);
    @(negedge forever_cpuclk);
    zero_inputs();
    #1;
    check_outputs();
    @(posedge forever_cpuclk);
    #2;
    cpurst_b = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #1;
    check_outputs();
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    rstep(0, 0, 0, 1, 0);

    // Random traffic, including flushes and occasional overflow.
    for (int i = 0; i < 400; i++) begin
      rstep(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
